// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/check engine for an N_IN-input combinational unit.
// Optional response signature register enabled by `define SWEEP_SIGNATURE_EN.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N_OUT-1:0] dut_resp,
    input  logic [N_OUT-1:0] exp_resp,
`ifdef SWEEP_SIGNATURE_EN
    output logic [15:0]      signature,
`endif
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);

    localparam int EW = N_IN + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0] cnt_q;
    logic          sample;
    logic          mismatch;
    logic          last_vec;
    logic [EW-1:0] err_inc;

    assign sample   = (state_q == S_APPLY) && (cnt_q == CNT_LAST);
    assign mismatch = (dut_resp != exp_resp);
    assign last_vec = &vec_out;
    assign err_inc  = err_count + EW'(mismatch);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (sample && last_vec) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All status outputs are registered so nothing depends combinationally on the responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_out         <= '0;
            cnt_q           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_out         <= '0;
                        cnt_q           <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (sample) begin
                        cnt_q     <= '0;
                        err_count <= err_inc;
                        if (mismatch && !first_err_valid) begin
                            first_err_vec   <= vec_out;
                            first_err_valid <= 1'b1;
                        end
                        if (last_vec) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_inc == '0);
                        end else begin
                            vec_out <= vec_out + N_IN'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SWEEP_SIGNATURE_EN
    logic [15:0] sig_q;
    logic [15:0] sig_next;

    assign sig_next  = {sig_q[14:0], 1'b0}
                     ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                     ^ 16'(dut_resp);
    assign signature = sig_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 16'hFFFF;
        end else if ((state_q != S_APPLY) && start) begin
            sig_q <= 16'hFFFF;
        end else if (sample) begin
            sig_q <= sig_next;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: directed plus randomized sweeps
// against a per-vector mismatch model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic       dut_resp;
    logic       exp_resp;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
    logic       first_err_valid;

    logic       start2;
    logic [3:0] d2;
    logic [3:0] e2;
    logic [3:0] v2;
    logic       b2;
    logic       dn2;
    logic       p2;
    logic [4:0] ec2;
    logic [3:0] fv2;
    logic       fvv2;

`ifdef SWEEP_SIGNATURE_EN
    logic [15:0] signature;
    logic [15:0] sig2;
`endif

    int   mode;
    logic f;
    logic rtab[8];
    logic rmask[8];
    logic [3:0] rt2[16];
    logic [3:0] rm2[16];

    int checks = 0;
    int failures = 0;

    truth_table_sweeper u1 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .dut_resp(dut_resp), .exp_resp(exp_resp),
`ifdef SWEEP_SIGNATURE_EN
        .signature(signature),
`endif
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_vec(first_err_vec),
        .first_err_valid(first_err_valid)
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(4), .SETTLE(3)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .dut_resp(d2), .exp_resp(e2),
`ifdef SWEEP_SIGNATURE_EN
        .signature(sig2),
`endif
        .vec_out(v2), .busy(b2), .done(dn2), .pass(p2),
        .err_count(ec2), .first_err_vec(fv2),
        .first_err_valid(fvv2)
    );

    always_comb begin
        f = (vec_out[2] & vec_out[1]) | vec_out[0];
        dut_resp = f;
        exp_resp = f;
        case (mode)
            1: dut_resp = f ^ (vec_out == 3'd5);
            2: begin
                dut_resp = 1'b0;
                exp_resp = ^vec_out;
            end
            3: begin
                exp_resp = rtab[vec_out];
                dut_resp = rtab[vec_out] ^ rmask[vec_out];
            end
            4: begin
                dut_resp = vec_out[0];
                exp_resp = vec_out[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        e2 = rt2[v2];
        d2 = rt2[v2] ^ rm2[v2];
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit mis(int m, int v);
        int ones;
        ones = 0;
        for (int b = 0; b < 3; b++) ones += (v >> b) & 1;
        case (m)
            1: return v == 5;
            2: return (ones % 2) == 1;
            3: return rmask[v];
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_done", done, 0);
        chk("acc_pass", pass, 0);
        chk("acc_err", err_count, 0);
        chk("acc_fevv", first_err_valid, 0);
        chk("acc_fev", first_err_vec, 0);
        chk("acc_vec", vec_out, 0);
    endtask

    task automatic wait_done(input bit steps, input int inj, output int de);
        int  e;
        bit  fired;
        e = 0;
        fired = 0;
        while (!done && e < 300) begin
            if (steps) chk("step_vec", vec_out, e / 2);
            start = 1'b0;
            if (!fired && inj >= 0 && int'(vec_out) == inj) begin
                start = 1'b1;
                fired = 1;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        start = 1'b0;
        de = done ? e : -1;
    endtask

    task automatic chk_res(int m);
        int n;
        int fe;
        n = 0;
        fe = -1;
        for (int v = 0; v < 8; v++) begin
            if (mis(m, v)) begin
                n++;
                if (fe < 0) fe = v;
            end
        end
        chk("res_done", done, 1);
        chk("res_busy", busy, 0);
        chk("res_vec", vec_out, 7);
        chk("res_err", err_count, n);
        chk("res_pass", pass, n == 0);
        chk("res_fevv", first_err_valid, fe >= 0);
        chk("res_fev", first_err_vec, (fe >= 0) ? fe : 0);
    endtask

    initial begin
        int de;
        int e;
        int n;
        int fe;
        mode = 0;
        start = 1'b0;
        start2 = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rtab[i] = 1'b0;
            rmask[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            rt2[i] = 4'h0;
            rm2[i] = 4'h0;
        end
        #12;
        chk("rst_vec", vec_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fevv", first_err_valid, 0);
        chk("rst_fev", first_err_vec, 0);
`ifdef SWEEP_SIGNATURE_EN
        chk("rst_sig", signature, 16'hFFFF);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int m = 0; m < 3; m++) begin
            mode = m;
            do_start();
            wait_done(m == 0, -1, de);
            chk("done_edge", de, 16);
            chk_res(m);
        end

        mode = 0;
        do_start();
        wait_done(0, -1, de);
        chk_res(0);

        mode = 3;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                rtab[i] = 1'($urandom);
                rmask[i] = ($urandom_range(0, 2) == 0);
            end
            do_start();
            wait_done(0, -1, de);
            chk("rnd_edge", de, 16);
            chk_res(3);
        end

        mode = 0;
        do_start();
        wait_done(0, 3, de);
        chk("ign_edge", de, 16);
        chk_res(0);

        mode = 2;
        do_start();
        e = 0;
        while (vec_out != 3'd4 && e < 50) begin
            @(negedge clk);
            e++;
        end
        chk("reach_v4", vec_out, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vec", vec_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_err", err_count, 0);
        chk("arst_fevv", first_err_valid, 0);
        chk("arst_fev", first_err_vec, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_vec", vec_out, 0);
        mode = 0;
        do_start();
        wait_done(0, -1, de);
        chk("clean_edge", de, 16);
        chk_res(0);

        for (int k = 0; k < 2; k++) begin
            n = 0;
            fe = -1;
            for (int i = 0; i < 16; i++) begin
                rt2[i] = 4'($urandom);
                rm2[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                if (rm2[i] != 4'h0) begin
                    n++;
                    if (fe < 0) fe = i;
                end
            end
            @(negedge clk);
            start2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            chk("u2_acc_busy", b2, 1);
            chk("u2_acc_vec", v2, 0);
            e = 0;
            while (!dn2 && e < 300) begin
                @(posedge clk);
                e++;
                @(negedge clk);
            end
            chk("u2_edge", e, 48);
            chk("u2_err", ec2, n);
            chk("u2_pass", p2, n == 0);
            chk("u2_fevv", fvv2, fe >= 0);
            chk("u2_fev", fv2, (fe >= 0) ? fe : 0);
            chk("u2_vec", v2, 15);
        end

`ifdef SWEEP_SIGNATURE_EN
        begin
            logic [15:0] s;
            mode = 4;
            do_start();
            chk("sig_init", signature, 16'hFFFF);
            wait_done(0, -1, de);
            s = 16'hFFFF;
            for (int v = 0; v < 8; v++) begin
                s = ((s << 1) & 16'hFFFF) ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'(v % 2);
            end
            chk("sig_final", signature, s);
            repeat (3) @(negedge clk);
            chk("sig_frozen", signature, s);
            chk_res(4);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential successor to the lab's fixed 3-input exhaustive testbench loop: a synthesizable stimulus/check engine that walks every input combination of an N_IN-input combinational unit.
- Each vector is held for a programmable settle time, then the unit's response is compared against a reference model's expected response.
- Mismatches are counted, and the first failing vector is recorded.
- Sits between a board-level start button/status LEDs and any combinational lab circuit plus its golden model.

## Interface

Parameters:
- N_IN, 3, number of inputs driven to the unit under check (1–16)
- N_OUT, 1, number of response bits compared (1–16)
- SETTLE, 2, clock cycles each vector is held before sampling (≥1)

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; sampled on rising edge; ignored while busy
- dut_resp  in  N_OUT  response of the circuit under check
- exp_resp  in  N_OUT  response of the reference model for the same vec_out
- vec_out  out  N_IN  stimulus vector driven to both the circuit and the model
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until the next start or reset
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  N_IN+1  number of mismatching vectors in the current/last sweep
- first_err_vec  out  N_IN  first vector that mismatched
- first_err_valid  out  1  first_err_vec holds a captured value
- signature  out  16  response signature (present only with SWEEP_SIGNATURE_EN)

## Operation

- States:
  - IDLE (after reset)
  - APPLY (sweep running)
  - DONE (result held)
- IDLE or DONE, start=1:
  - Go to APPLY.
  - vec_out←0, settle counter←0.
  - err_count←0, first_err_valid←0, first_err_vec←0, done←0, pass←0.
  - Signature←16'hFFFF.
- APPLY, cycle by cycle:
  - Settle counter increments each cycle.
  - On the cycle where counter==SETTLE-1, sample: mismatch iff dut_resp!=exp_resp (full-width compare).
  - On mismatch, err_count increments. If first_err_valid=0, capture first_err_vec←vec_out and set first_err_valid←1.
  - After the sample, if vec_out==all-ones go to DONE; otherwise vec_out←vec_out+1 and counter←0.
- DONE: busy=0, done=1, pass=(err_count==0). vec_out holds the last vector (all-ones).
- start while in APPLY is ignored; there is no abort input other than reset_n.
- err_count cannot overflow: its width N_IN+1 holds the maximum value 2^N_IN.
- Reset values (reset_n low, any state, takes effect immediately):
  - State IDLE.
  - vec_out=0, busy=0, done=0, pass=0.
  - err_count=0, first_err_vec=0, first_err_valid=0.
  - signature=16'hFFFF.
- Reset mid-sweep discards partial results. The next start begins a fresh sweep from vector 0.

## Timing

- busy rises and vec_out=0 on the first edge after start is sampled (edge 0).
- Each vector is held exactly SETTLE cycles. Sampling uses values present in the cycle before the sampling edge.
- Total sweep: 2^N_IN × SETTLE cycles.
- done=1 and busy=0 after edge 2^N_IN × SETTLE. For the defaults this is edge 16.
- err_count and first_err_* update on the sampling edge, with no extra latency.
- A restart from DONE clears done and pass on the same edge that accepts start.
- All outputs are registered. There is no combinational path from dut_resp or exp_resp to any output.

## Configuration

SWEEP_SIGNATURE_EN
- Defined: the signature port exists. On every sampling edge:
  - sig←{sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ zero-extended dut_resp.
  - The value is frozen in DONE.
  - Used to fingerprint a circuit without a reference model.
- Undefined: no signature port and no signature logic. All other behaviour is identical.

## Test plan

- Defaults; exp_resp = dut_resp = A&B|C of vec_out; start pulsed.
  - Required: vec_out steps 0..7, each held 2 cycles.
  - Required: done=1 at edge 16, err_count=0, pass=1, first_err_valid=0.
- dut_resp inverted only when vec_out==5.
  - Required: err_count=1, first_err_vec=5, first_err_valid=1, pass=0.
- dut_resp=0 and exp_resp=^vec_out (parity).
  - Required: err_count=4, first_err_vec=1.
- start re-pulsed while vec_out==3: ignored, done still at edge 16.
  - Then reset_n pulsed low while vec_out==4: all outputs return to reset values asynchronously.
  - Then a new start: completes a clean sweep.
- Restart from DONE after a failing sweep.
  - Required: err_count=0, done=0, first_err_valid=0 on the accept edge.
  - Then N_IN=4, SETTLE=3: done at edge 48.
- With SWEEP_SIGNATURE_EN, dut_resp=vec_out[0].
  - Required: signature at done equals the bench model of the stated update over 8 samples, starting from 16'hFFFF.
  - Required: without the macro, the block elaborates with no signature port.
